// File: rtl/lane_select_sequencer.sv
// Arbitrated sequencer for a 16-lane select datapath: grants one of two requesters,
// holds the decoded select controls for SETTLE cycles, then captures and presents the result.
// Optional DONE-state abandonment timer is enabled by defining SEL_TIMEOUT_EN.
module lane_select_sequencer #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [1:0]  mode_a,
  input  logic [1:0]  mode_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        sel_u,
  output logic        sel_t,
  output logic        sel_s,
  input  logic [15:0] dp_res,
  output logic [15:0] res,
  output logic        res_src,
  output logic        res_valid,
  input  logic        res_ack,
  output logic        busy
`ifdef SEL_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic        owner_q, owner_d;
  logic        last_b_q, last_b_d;
  logic [15:0] res_q, res_d;
  logic        res_src_q, res_src_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        win_b;
  logic [2:0]  sel_vec;

`ifdef SEL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  tcnt_q, tcnt_d;
  logic        timeout_q, timeout_d;
`endif

  // On a tie the requester not served last wins; last_b resets high so A wins first.
  always_comb begin
    win_b = req_b && (!req_a || !last_b_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    owner_d   = owner_q;
    last_b_d  = last_b_q;
    res_d     = res_q;
    res_src_d = res_src_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
`ifdef SEL_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          mode_d   = win_b ? mode_b : mode_a;
          owner_d  = win_b;
          last_b_d = win_b;
          gnt_a_d  = !win_b;
          gnt_b_d  = win_b;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETTLE_LAST) begin
          res_d     = dp_res;
          res_src_d = owner_q;
          cnt_d     = '0;
          state_d   = DONE;
`ifdef SEL_TIMEOUT_EN
          tcnt_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (res_ack) begin
          state_d = IDLE;
`ifdef SEL_TIMEOUT_EN
          tcnt_d  = '0;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          state_d   = IDLE;
          tcnt_d    = '0;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      owner_q   <= 1'b0;
      last_b_q  <= 1'b1;
      res_q     <= '0;
      res_src_q <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
`ifdef SEL_TIMEOUT_EN
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      owner_q   <= owner_d;
      last_b_q  <= last_b_d;
      res_q     <= res_d;
      res_src_q <= res_src_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
`ifdef SEL_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Controls come from the latched mode, so mode input changes mid-operation are ignored.
  always_comb begin
    sel_vec = 3'b000;
    if (state_q != IDLE) begin
      case (mode_q)
        2'b00:   sel_vec = 3'b000;
        2'b01:   sel_vec = 3'b100;
        2'b10:   sel_vec = 3'b110;
        default: sel_vec = 3'b101;
      endcase
    end
  end

  assign {sel_u, sel_t, sel_s} = sel_vec;
  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign res       = res_q;
  assign res_src   = res_src_q;
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
`ifdef SEL_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_lane_select_sequencer.sv
// Randomized bench for lane_select_sequencer against a timeline-based reference model
// (operation age since grant), plus short directed scenarios.
module tb_lane_select_sequencer;

  localparam int unsigned SETTLE = 2;
`ifdef SEL_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int unsigned TIMEOUT = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_a, req_b;
  logic [1:0]  mode_a, mode_b;
  logic        gnt_a, gnt_b;
  logic        sel_u, sel_t, sel_s;
  logic [15:0] dp_res;
  logic [15:0] res;
  logic        res_src;
  logic        res_valid;
  logic        res_ack;
  logic        busy;
  logic        timeout;

  lane_select_sequencer #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .mode_a    (mode_a),
    .mode_b    (mode_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel_u     (sel_u),
    .sel_t     (sel_t),
    .sel_s     (sel_s),
    .dp_res    (dp_res),
    .res       (res),
    .res_src   (res_src),
    .res_valid (res_valid),
    .res_ack   (res_ack),
    .busy      (busy)
`ifdef SEL_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

`ifndef SEL_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an operation is described by its age in cycles since the grant edge.
  logic [2:0]  sel_tbl [4] = '{3'b000, 3'b100, 3'b110, 3'b101};
  bit          m_active;
  int unsigned m_age;
  logic [1:0]  m_mode;
  bit          m_owner;
  bit          m_last_b;
  logic [15:0] m_res;
  bit          m_src;
  bit          m_gnt_a, m_gnt_b, m_to;

  task automatic model_edge();
    m_gnt_a = 1'b0;
    m_gnt_b = 1'b0;
    m_to    = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_age = 0; m_mode = 2'b00; m_owner = 1'b0;
      m_last_b = 1'b1; m_res = '0; m_src = 1'b0;
    end else if (!m_active) begin
      if (req_a || req_b) begin
        if (req_a && req_b) m_owner = !m_last_b;
        else                m_owner = req_b;
        m_mode   = m_owner ? mode_b : mode_a;
        m_last_b = m_owner;
        m_gnt_a  = !m_owner;
        m_gnt_b  = m_owner;
        m_active = 1'b1;
        m_age    = 1;
      end
    end else if (m_age <= SETTLE) begin
      if (m_age == SETTLE) begin
        m_res = dp_res;
        m_src = m_owner;
      end
      m_age++;
    end else begin
      if (res_ack) m_active = 1'b0;
      else if (TO_EN && (m_age - SETTLE) == TIMEOUT) begin
        m_active = 1'b0;
        m_to     = 1'b1;
      end else m_age++;
    end
  endtask

  task automatic compare_all();
    logic [2:0] exp_sel;
    exp_sel = m_active ? sel_tbl[m_mode] : 3'b000;
    chk("gnt_a",     32'(gnt_a),     32'(m_gnt_a));
    chk("gnt_b",     32'(gnt_b),     32'(m_gnt_b));
    chk("sel",       32'({sel_u, sel_t, sel_s}), 32'(exp_sel));
    chk("busy",      32'(busy),      32'(m_active));
    chk("res_valid", 32'(res_valid), 32'(m_active && m_age > SETTLE));
    chk("res",       32'(res),       32'(m_res));
    chk("res_src",   32'(res_src),   32'(m_src));
    if (TO_EN) chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic step(input logic rn, input logic ra, input logic rb,
                      input logic [1:0] ma, input logic [1:0] mb,
                      input logic [15:0] dp, input logic ack);
    rst_n = rn; req_a = ra; req_b = rb; mode_a = ma; mode_b = mb;
    dp_res = dp; res_ack = ack;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  bit exp_next_b;

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; mode_a = '0; mode_b = '0;
    dp_res = '0; res_ack = 1'b0;

    // Reset state
    step(0, 0, 0, 2'b00, 2'b00, 16'hFFFF, 0);
    step(0, 1, 1, 2'b11, 2'b11, 16'hFFFF, 1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res",  32'(res),  32'd0);

    // Single request A, mode alternate; mode changes after grant must not matter
    step(1, 1, 0, 2'b10, 2'b00, 16'h1111, 0);
    chk("a_gnt", 32'(gnt_a), 32'd1);
    step(1, 0, 0, 2'b01, 2'b11, 16'h2222, 0);
    step(1, 0, 0, 2'b11, 2'b01, 16'h3C3C, 0);
    chk("a_res", 32'(res), 32'h3C3C);
    chk("a_valid", 32'(res_valid), 32'd1);
    step(1, 0, 0, 2'b00, 2'b00, 16'h4444, 1);

    // Requester B, force mode; result persists after returning to IDLE
    step(1, 0, 1, 2'b00, 2'b11, 16'hA5C3, 0);
    step(1, 0, 0, 2'b00, 2'b00, 16'hA5C3, 1);
    step(1, 0, 0, 2'b00, 2'b00, 16'hA5C3, 1);
    chk("b_sel", 32'({sel_u, sel_t, sel_s}), 32'(3'b101));
    step(1, 0, 0, 2'b00, 2'b00, 16'h0000, 1);
    chk("b_hold_res", 32'(res), 32'hA5C3);
    chk("b_hold_sel", 32'({sel_u, sel_t, sel_s}), 32'd0);

    // Both held, immediate ack: grants alternate starting with A after reset
    step(0, 0, 0, 2'b00, 2'b00, 16'h0, 0);
    exp_next_b = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1, 1, 1, 2'(i), 2'(i + 1), 16'(i * 16'h0101), 1);
      if (gnt_a || gnt_b) begin
        chk("alternate", 32'(gnt_b), 32'(exp_next_b));
        exp_next_b = !exp_next_b;
      end
    end

    // Reset during the second SETUP cycle with req_b held through reset
    step(0, 0, 0, 2'b00, 2'b00, 16'h0, 0);
    step(1, 1, 0, 2'b01, 2'b00, 16'h5555, 0);
    step(1, 0, 1, 2'b01, 2'b10, 16'h5555, 0);
    step(0, 0, 1, 2'b01, 2'b10, 16'h5555, 0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sel",  32'({sel_u, sel_t, sel_s}), 32'd0);
    chk("mid_rst_res",  32'(res), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    step(1, 0, 1, 2'b01, 2'b10, 16'h5555, 0);
    chk("post_rst_gnt_b", 32'(gnt_b), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 2'b00, 2'b00, 16'h6666, 1);

    // DONE dwell without ack (abandons when the timer is present), then ack on the last allowed cycle
    step(1, 0, 0, 2'b00, 2'b00, 16'h0, 1);
    step(1, 1, 0, 2'b01, 2'b00, 16'h7777, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 2'b00, 2'b00, 16'h7777, 0);
    step(1, 0, 0, 2'b00, 2'b00, 16'h0, 1);
    step(1, 0, 1, 2'b00, 2'b10, 16'h8888, 0);
    for (int i = 0; i < SETTLE + 3; i++) step(1, 0, 0, 2'b00, 2'b00, 16'h8888, 0);
    step(1, 0, 0, 2'b00, 2'b00, 16'h8888, 1);
    step(1, 0, 0, 2'b00, 2'b00, 16'h8888, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) >= 3),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 55),
           2'($urandom), 2'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < 35));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
